// File: rtl/pic_stream.sv
// Streaming sparse-index intersection: merges two ascending index streams, queues
// matched value pairs plus an end-of-vector match-count marker in a FWFT FIFO.
module pic_stream #(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned VAL_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [IDX_W-1:0]           a_idx,
  input  logic [VAL_W-1:0]           a_val,
  input  logic                       a_last,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [IDX_W-1:0]           b_idx,
  input  logic [VAL_W-1:0]           b_val,
  input  logic                       b_last,
  input  logic                       out_rd,
  output logic                       out_valid,
  output logic [2*VAL_W-1:0]         out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 2 * VAL_W;

  typedef enum logic [1:0] {RUN, DRAIN_A, DRAIN_B, EOV} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_mem_data [DEPTH];
  logic [IDX_W-1:0] r_mem_idx  [DEPTH];
  logic             r_mem_last [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [IDX_W-1:0] r_match_cnt;

  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_a_rdy;
  logic             w_b_rdy;
  logic             w_push;
  logic [DW-1:0]    w_push_data;
  logic [IDX_W-1:0] w_push_idx;
  logic             w_push_last;
  logic             w_pop;
  logic             w_a_end;
  logic             w_b_end;

  // Occupancy derives from the extra pointer bit, so full and empty stay distinct.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == CW'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_pop   = out_rd & ~w_empty;

  always_comb begin
    w_a_rdy     = 1'b0;
    w_b_rdy     = 1'b0;
    w_push      = 1'b0;
    w_push_data = '0;
    w_push_idx  = '0;
    w_push_last = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (a_valid && b_valid) begin
            if (a_idx < b_idx) begin
              w_a_rdy = 1'b1;
            end else if (a_idx > b_idx) begin
              w_b_rdy = 1'b1;
            end else if (!w_full) begin
              w_a_rdy     = 1'b1;
              w_b_rdy     = 1'b1;
              w_push      = 1'b1;
              w_push_data = {a_val, b_val};
              w_push_idx  = a_idx;
            end
          end
        end
        DRAIN_A: w_a_rdy = a_valid;
        DRAIN_B: w_b_rdy = b_valid;
        EOV: begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_push_last = 1'b1;
            w_push_data = DW'(r_match_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_a_end = a_valid & w_a_rdy & a_last;
  assign w_b_end = b_valid & w_b_rdy & b_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_match_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case (r_state)
        RUN: begin
          if (w_push && r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
          if (w_a_end && w_b_end)  r_state <= EOV;
          else if (w_a_end)        r_state <= DRAIN_B;
          else if (w_b_end)        r_state <= DRAIN_A;
        end
        DRAIN_A: if (w_a_end) r_state <= EOV;
        DRAIN_B: if (w_b_end) r_state <= EOV;
        EOV: begin
          if (w_push) begin
            r_match_cnt <= '0;
            r_state     <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= w_push_data;
      r_mem_idx[r_wr_ptr[AW-1:0]]  <= w_push_idx;
      r_mem_last[r_wr_ptr[AW-1:0]] <= w_push_last;
    end
  end

  assign a_ready   = w_a_rdy;
  assign b_ready   = w_b_rdy;
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr[AW-1:0]];
  assign out_idx   = w_empty ? '0 : r_mem_idx[r_rd_ptr[AW-1:0]];
  assign out_last  = w_empty ? 1'b0 : r_mem_last[r_rd_ptr[AW-1:0]];
  assign full      = w_full;
  assign count     = w_count;

endmodule

// File: tb/tb_pic_stream.sv
// Directed bench for pic_stream: merge-intersection vectors, FIFO full/stall, reset.
module tb_pic_stream;
  localparam int IDX_W = 16;
  localparam int VAL_W = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, a_ready, a_last;
  logic [IDX_W-1:0]  a_idx;
  logic [VAL_W-1:0]  a_val;
  logic              b_valid, b_ready, b_last;
  logic [IDX_W-1:0]  b_idx;
  logic [VAL_W-1:0]  b_val;
  logic              out_rd, out_valid, out_last, full;
  logic [2*VAL_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [3:0]        count;

  pic_stream #(.IDX_W(IDX_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .out_rd(out_rd), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] sa_idx [4];
  logic [15:0] sb_idx [4];
  logic [31:0] rec_data [16];
  logic [15:0] rec_idx [16];
  logic        rec_last [16];
  int          rec_cyc [16];
  int          rec_n, a_takes, b_takes, a_last_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [15:0] i0, input logic [15:0] i1,
                        input logic [15:0] i2, input logic [15:0] i3);
    sa_idx[0] = i0; sa_idx[1] = i1; sa_idx[2] = i2; sa_idx[3] = i3;
  endtask

  task automatic load_b(input logic [15:0] i0, input logic [15:0] i1,
                        input logic [15:0] i2, input logic [15:0] i3);
    sb_idx[0] = i0; sb_idx[1] = i1; sb_idx[2] = i2; sb_idx[3] = i3;
  endtask

  // Streams values 16'hA000+idx / 16'hB000+idx; cycle 1 is the first driven cycle.
  task automatic run_vec(input int na, input int nb, input int budget);
    int pa, pb;
    bit done, at, bt;
    pa = 0; pb = 0; done = 0;
    rec_n = 0; a_takes = 0; b_takes = 0; a_last_cyc = 0;
    for (int cyc = 1; cyc <= budget && !done; cyc++) begin
      @(negedge clk);
      a_valid = (pa < na);
      b_valid = (pb < nb);
      if (pa < na) begin
        a_idx = sa_idx[pa]; a_val = 16'hA000 + sa_idx[pa]; a_last = (pa == na - 1);
      end else begin
        a_idx = '0; a_val = '0; a_last = 1'b0;
      end
      if (pb < nb) begin
        b_idx = sb_idx[pb]; b_val = 16'hB000 + sb_idx[pb]; b_last = (pb == nb - 1);
      end else begin
        b_idx = '0; b_val = '0; b_last = 1'b0;
      end
      #1;
      at = a_valid & a_ready;
      bt = b_valid & b_ready;
      if (out_rd && out_valid && rec_n < 16) begin
        rec_data[rec_n] = out_data;
        rec_idx[rec_n]  = out_idx;
        rec_last[rec_n] = out_last;
        rec_cyc[rec_n]  = cyc;
        rec_n++;
        if (out_last) done = 1;
      end
      if (at) begin
        a_takes++;
        if (a_last) a_last_cyc = cyc;
        pa++;
      end
      if (bt) begin
        b_takes++;
        pb++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    check("vec_done", done, 1);
  endtask

  task automatic drive_pair(input logic [15:0] idx, input logic last);
    a_valid = 1'b1; b_valid = 1'b1;
    a_idx = idx; b_idx = idx;
    a_val = 16'hA000 + idx; b_val = 16'hB000 + idx;
    a_last = last; b_last = last;
  endtask

  initial begin
    rst = 1'b1; out_rd = 1'b0;
    drive_pair(16'd4, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_head", {out_data, out_idx, out_last}, 0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // Basic intersection: A{1,3,5,7} B{3,4,7}
    out_rd = 1'b1;
    load_a(1, 3, 5, 7); load_b(3, 4, 7, 0);
    run_vec(4, 3, 40);
    check("t1_n", rec_n, 3);
    check("t1_p0", {rec_idx[0], rec_data[0], rec_last[0]}, {16'd3, 32'hA003B003, 1'b0});
    check("t1_p0_cyc", rec_cyc[0], 3);
    check("t1_p1", {rec_idx[1], rec_data[1], rec_last[1]}, {16'd7, 32'hA007B007, 1'b0});
    check("t1_p1_cyc", rec_cyc[1], 6);
    check("t1_mark", {rec_idx[2], rec_data[2], rec_last[2]}, {16'd0, 32'd2, 1'b1});
    check("t1_mark_cyc", rec_cyc[2], 7);
    check("t1_a_takes", a_takes, 4);
    check("t1_a_last_cyc", a_last_cyc, 5);
    check("t1_b_takes", b_takes, 3);

    // Disjoint streams: only a zero-count marker
    load_a(0, 2, 0, 0); load_b(1, 3, 0, 0);
    run_vec(2, 2, 40);
    check("t2_n", rec_n, 1);
    check("t2_mark", {rec_idx[0], rec_data[0], rec_last[0]}, {16'd0, 32'd0, 1'b1});
    check("t2_mark_cyc", rec_cyc[0], 6);

    // A ends first; B drained
    load_a(5, 0, 0, 0); load_b(1, 2, 9, 10);
    run_vec(1, 4, 40);
    check("t4_n", rec_n, 1);
    check("t4_mark", {rec_data[0], rec_last[0]}, {32'd0, 1'b1});
    check("t4_a_last_cyc", a_last_cyc, 3);
    check("t4_b_takes", b_takes, 4);

    // Both last on equal index: pair then marker in consecutive cycles
    load_a(4, 0, 0, 0); load_b(4, 0, 0, 0);
    run_vec(1, 1, 40);
    check("t5_n", rec_n, 2);
    check("t5_pair", {rec_idx[0], rec_data[0], rec_last[0]}, {16'd4, 32'hA004B004, 1'b0});
    check("t5_mark", {rec_data[1], rec_last[1]}, {32'd1, 1'b1});
    check("t5_cyc", {rec_cyc[0][7:0], rec_cyc[1][7:0]}, {8'd2, 8'd3});

    // FIFO fill: 9 matching pairs with no pops
    out_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_pair(16'(i), 1'b0);
      #1;
      check("fill_ready", {a_ready, b_ready}, 2'b11);
      @(posedge clk);
    end
    @(negedge clk);
    drive_pair(16'd8, 1'b1);
    #1;
    check("full_flag", full, 1);
    check("full_count", count, 8);
    check("full_stall", {a_ready, b_ready}, 2'b00);
    check("full_head", {out_idx, out_data}, {16'd0, 32'hA000B000});
    out_rd = 1'b1;
    #1;
    check("full_no_bypass", {a_ready, b_ready}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    out_rd = 1'b0;
    #1;
    check("after_pop_count", count, 7);
    check("after_pop_ready", {a_ready, b_ready, full}, 3'b110);
    check("after_pop_head", out_idx, 1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("ninth_count", count, 8);
    check("ninth_full", full, 1);
    out_rd = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      check("drain_valid", out_valid, 1);
      if (k < 8) check("drain_pair", {out_idx, out_data, out_last},
                       {16'(k + 1), 16'hA000 + 16'(k + 1), 16'hB000 + 16'(k + 1), 1'b0});
      else       check("drain_mark", {out_idx, out_data, out_last}, {16'd0, 32'd9, 1'b1});
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("drained_empty", {out_valid, count}, 5'd0);

    // Reset mid-vector with three queued entries
    out_rd = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive_pair(16'(i), 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    drive_pair(16'd4, 1'b0);
    #1;
    check("pre_rst_count", count, 3);
    rst = 1'b1;
    #1;
    check("in_rst_ready", {a_ready, b_ready}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("post_rst_count", count, 0);
    check("post_rst_valid", out_valid, 0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    out_rd = 1'b1;
    load_a(6, 0, 0, 0); load_b(6, 0, 0, 0);
    run_vec(1, 1, 40);
    check("post_rst_n", rec_n, 2);
    check("post_rst_pair", {rec_idx[0], rec_data[0]}, {16'd6, 32'hA006B006});
    check("post_rst_mark", {rec_data[1], rec_last[1]}, {32'd1, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
